// File: rtl/esp_uart_fifo.sv
// Parametrised UART transceiver with valid/ready TX/RX FIFOs and sticky RX error flags.
// state   | meaning
// R_IDLE  | wait for falling edge on synchronised rxd
// R_START | confirm start bit at half-bit
// R_DATA  | shift in DATA_BITS, LSB first
// R_PAR   | sample and check parity bit
// R_STOP  | sample first stop bit
// R_PUSH  | push frame into RX FIFO (or flag overrun)
// T_IDLE  | pop next word when TX FIFO non-empty
// T_START | drive start bit
// T_DATA  | drive DATA_BITS, LSB first
// T_PAR   | drive parity bit
// T_STOP  | drive STOP_BITS stop bits
module esp_uart_fifo #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic                          uart_rxd,
   output logic                          uart_txd,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          err_overrun,
   input  logic                          err_clear
);
   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int CW  = $clog2(STOP_BITS * DIV + 1);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_STOP = CW'(STOP_BITS * DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic          PAR_ODD  = (PARITY == 1);

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_PUSH} rx_state_t;
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

   logic rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d, rxd_prev_q, rxd_prev_d;

   rx_state_t            rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
   logic                 rx_push_req, rx_push, rx_pop, rx_full, rx_ovr;
   logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
   logic [AW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [LW-1:0]        rx_level_q, rx_level_d;

   tx_state_t            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, tx_head;
   logic                 tx_par_q, tx_par_d, txd_q, txd_d;
   logic                 tx_push, tx_pop;
   logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
   logic [AW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [LW-1:0]        tx_level_q, tx_level_d;

   logic err_parity_q, err_parity_d, err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;

   always_comb begin
      rxd_s1_d   = uart_rxd;
      rxd_s2_d   = rxd_s1_q;
      rxd_prev_d = rxd_s2_q;
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_sh_d     = rx_sh_q;
      rx_perr_d   = rx_perr_q;
      rx_ferr_d   = rx_ferr_q;
      rx_push_req = 1'b0;
      case (rx_state_q)
         R_IDLE: if (rxd_prev_q && !rxd_s2_q) begin
            rx_state_d = R_START;
            rx_cnt_d   = CNT_HALF;
            rx_perr_d  = 1'b0;
            rx_ferr_d  = 1'b0;
         end
         R_START: if (rx_cnt_q == '0) begin
            if (rxd_s2_q) begin
               rx_state_d = R_IDLE;
            end else begin
               rx_state_d = R_DATA;
               rx_cnt_d   = CNT_BIT;
               rx_bit_d   = '0;
            end
         end else rx_cnt_d = rx_cnt_q - CNT_ONE;
         R_DATA: if (rx_cnt_q == '0) begin
            rx_sh_d  = {rxd_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_d = CNT_BIT;
            rx_bit_d = rx_bit_q + BIT_ONE;
            if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != 0) ? R_PAR : R_STOP;
         end else rx_cnt_d = rx_cnt_q - CNT_ONE;
         R_PAR: if (rx_cnt_q == '0) begin
            rx_perr_d  = rxd_s2_q ^ (^rx_sh_q) ^ PAR_ODD;
            rx_cnt_d   = CNT_BIT;
            rx_state_d = R_STOP;
         end else rx_cnt_d = rx_cnt_q - CNT_ONE;
         R_STOP: if (rx_cnt_q == '0) begin
            rx_ferr_d  = !rxd_s2_q;
            rx_state_d = R_PUSH;
         end else rx_cnt_d = rx_cnt_q - CNT_ONE;
         R_PUSH: begin
            rx_push_req = 1'b1;
            rx_state_d  = R_IDLE;
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // A full RX FIFO still accepts a frame when the head is popped in the same cycle.
   assign rx_valid = (rx_level_q != '0);
   assign rx_pop   = rx_valid && rx_ready;
   assign rx_full  = (rx_level_q == LVL_FULL);
   assign rx_push  = rx_push_req && (!rx_full || rx_pop);
   assign rx_ovr   = rx_push_req && rx_full && !rx_pop;
   assign tx_ready = (tx_level_q != LVL_FULL);
   assign tx_push  = tx_valid && tx_ready;
   assign tx_head  = tx_mem_q[tx_rd_q];

   always_comb begin
      rx_wr_d    = rx_wr_q;
      rx_rd_d    = rx_rd_q;
      rx_level_d = rx_level_q;
      tx_wr_d    = tx_wr_q;
      tx_rd_d    = tx_rd_q;
      tx_level_d = tx_level_q;
      if (rx_push) rx_wr_d = rx_wr_q + PTR_ONE;
      if (rx_pop)  rx_rd_d = rx_rd_q + PTR_ONE;
      if (rx_push && !rx_pop)      rx_level_d = rx_level_q + LVL_ONE;
      else if (!rx_push && rx_pop) rx_level_d = rx_level_q - LVL_ONE;
      if (tx_push) tx_wr_d = tx_wr_q + PTR_ONE;
      if (tx_pop)  tx_rd_d = tx_rd_q + PTR_ONE;
      if (tx_push && !tx_pop)      tx_level_d = tx_level_q + LVL_ONE;
      else if (!tx_push && tx_pop) tx_level_d = tx_level_q - LVL_ONE;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         T_IDLE: if (tx_level_q != '0) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            txd_d      = 1'b0;
            tx_cnt_d   = CNT_BIT;
            tx_state_d = T_START;
         end
         T_START: if (tx_cnt_q == '0) begin
            txd_d      = tx_sh_q[0];
            tx_cnt_d   = CNT_BIT;
            tx_bit_d   = '0;
            tx_state_d = T_DATA;
         end else tx_cnt_d = tx_cnt_q - CNT_ONE;
         T_DATA: if (tx_cnt_q == '0) begin
            tx_cnt_d = CNT_BIT;
            if (tx_bit_q != BIT_LAST) begin
               tx_bit_d = tx_bit_q + BIT_ONE;
               tx_sh_d  = {1'b0, tx_sh_q[DATA_BITS-1:1]};
               txd_d    = tx_sh_q[1];
            end else if (PARITY != 0) begin
               txd_d      = tx_par_q;
               tx_state_d = T_PAR;
            end else begin
               txd_d      = 1'b1;
               tx_cnt_d   = CNT_STOP;
               tx_state_d = T_STOP;
            end
         end else tx_cnt_d = tx_cnt_q - CNT_ONE;
         T_PAR: if (tx_cnt_q == '0) begin
            txd_d      = 1'b1;
            tx_cnt_d   = CNT_STOP;
            tx_state_d = T_STOP;
         end else tx_cnt_d = tx_cnt_q - CNT_ONE;
         T_STOP: if (tx_cnt_q == '0) begin
            txd_d      = 1'b1;
            tx_state_d = T_IDLE;
         end else tx_cnt_d = tx_cnt_q - CNT_ONE;
         default: begin
            txd_d      = 1'b1;
            tx_state_d = T_IDLE;
         end
      endcase
   end

   // Set has priority over clear.
   always_comb begin
      err_parity_d  = (rx_push_req && rx_perr_q) || (err_parity_q && !err_clear);
      err_frame_d   = (rx_push_req && rx_ferr_q) || (err_frame_q && !err_clear);
      err_overrun_d = rx_ovr || (err_overrun_q && !err_clear);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         rxd_s1_q      <= 1'b1;
         rxd_s2_q      <= 1'b1;
         rxd_prev_q    <= 1'b1;
         rx_state_q    <= R_IDLE;
         rx_cnt_q      <= '0;
         rx_bit_q      <= '0;
         rx_sh_q       <= '0;
         rx_perr_q     <= 1'b0;
         rx_ferr_q     <= 1'b0;
         rx_wr_q       <= '0;
         rx_rd_q       <= '0;
         rx_level_q    <= '0;
         tx_state_q    <= T_IDLE;
         tx_cnt_q      <= '0;
         tx_bit_q      <= '0;
         tx_sh_q       <= '0;
         tx_par_q      <= 1'b0;
         txd_q         <= 1'b1;
         tx_wr_q       <= '0;
         tx_rd_q       <= '0;
         tx_level_q    <= '0;
         err_parity_q  <= 1'b0;
         err_frame_q   <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         rxd_s1_q      <= rxd_s1_d;
         rxd_s2_q      <= rxd_s2_d;
         rxd_prev_q    <= rxd_prev_d;
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_bit_q      <= rx_bit_d;
         rx_sh_q       <= rx_sh_d;
         rx_perr_q     <= rx_perr_d;
         rx_ferr_q     <= rx_ferr_d;
         rx_wr_q       <= rx_wr_d;
         rx_rd_q       <= rx_rd_d;
         rx_level_q    <= rx_level_d;
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_bit_q      <= tx_bit_d;
         tx_sh_q       <= tx_sh_d;
         tx_par_q      <= tx_par_d;
         txd_q         <= txd_d;
         tx_wr_q       <= tx_wr_d;
         tx_rd_q       <= tx_rd_d;
         tx_level_q    <= tx_level_d;
         err_parity_q  <= err_parity_d;
         err_frame_q   <= err_frame_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (rx_push) rx_mem_q[rx_wr_q] <= rx_sh_q;
      if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
   end

   assign uart_txd    = txd_q;
   assign rx_data     = rx_valid ? rx_mem_q[rx_rd_q] : '0;
   assign tx_level    = tx_level_q;
   assign rx_level    = rx_level_q;
   assign err_parity  = err_parity_q;
   assign err_frame   = err_frame_q;
   assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_esp_uart_fifo.sv
// Directed bench: instance A is 8N1 with 16-deep FIFOs, instance B is 8E2 with 4-deep FIFOs.
module tb_esp_uart_fifo;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   logic       a_lb, a_drv, a_rxd, a_txd;
   logic [7:0] a_tx_data, a_rx_data;
   logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
   logic [4:0] a_tx_level, a_rx_level;
   logic       a_err_par, a_err_frm, a_err_ovr, a_err_clear;

   logic       b_lb, b_drv, b_rxd, b_txd;
   logic [7:0] b_tx_data, b_rx_data;
   logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
   logic [2:0] b_tx_level, b_rx_level;
   logic       b_err_par, b_err_frm, b_err_ovr, b_err_clear;

   logic       a_collect;
   logic [7:0] got_q[$];

   assign a_rxd = a_lb ? a_txd : a_drv;
   assign b_rxd = b_lb ? b_txd : b_drv;

   esp_uart_fifo #(.CLK_HZ(1000000), .BAUD(100000)) u_a (
      .clk_clk(clk), .reset_reset(rst), .uart_rxd(a_rxd), .uart_txd(a_txd),
      .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
      .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
      .tx_level(a_tx_level), .rx_level(a_rx_level),
      .err_parity(a_err_par), .err_frame(a_err_frm), .err_overrun(a_err_ovr),
      .err_clear(a_err_clear));

   esp_uart_fifo #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(2), .STOP_BITS(2),
                   .FIFO_DEPTH(4)) u_b (
      .clk_clk(clk), .reset_reset(rst), .uart_rxd(b_rxd), .uart_txd(b_txd),
      .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
      .tx_level(b_tx_level), .rx_level(b_rx_level),
      .err_parity(b_err_par), .err_frame(b_err_frm), .err_overrun(b_err_ovr),
      .err_clear(b_err_clear));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (a_collect && a_rx_valid && a_rx_ready) got_q.push_back(a_rx_data);

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input bit to_b, input logic [15:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if (to_b) b_drv = bits[i]; else a_drv = bits[i];
         step(10);
      end
      if (to_b) b_drv = 1'b1; else a_drv = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(3);
      n_checks++; if (a_txd !== 1'b1) $display("FAIL rst_a_txd: got %b, required 1", a_txd); else n_pass++;
      n_checks++; if (a_tx_ready !== 1'b1) $display("FAIL rst_a_tx_ready: got %b, required 1", a_tx_ready); else n_pass++;
      n_checks++; if (a_rx_valid !== 1'b0) $display("FAIL rst_a_rx_valid: got %b, required 0", a_rx_valid); else n_pass++;
      n_checks++; if (a_rx_data !== 8'h00) $display("FAIL rst_a_rx_data: got %h, required 00", a_rx_data); else n_pass++;
      n_checks++; if ({a_tx_level, a_rx_level} !== 10'd0) $display("FAIL rst_a_levels: got %h, required 0", {a_tx_level, a_rx_level}); else n_pass++;
      n_checks++; if ({a_err_par, a_err_frm, a_err_ovr} !== 3'b000) $display("FAIL rst_a_err: got %b, required 000", {a_err_par, a_err_frm, a_err_ovr}); else n_pass++;
      n_checks++; if (b_txd !== 1'b1) $display("FAIL rst_b_txd: got %b, required 1", b_txd); else n_pass++;
      n_checks++; if ({b_tx_level, b_rx_level} !== 6'd0) $display("FAIL rst_b_levels: got %h, required 0", {b_tx_level, b_rx_level}); else n_pass++;
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_loopback;
      logic [9:0] fr;
      logic bad, seen;
      int k;
      fr = {1'b1, 8'hA5, 1'b0};
      a_lb = 1'b1;
      a_tx_data = 8'hA5; a_tx_valid = 1'b1; step(1); a_tx_valid = 1'b0;
      k = 0;
      while (a_txd !== 1'b0 && k < 20) begin step(1); k++; end
      n_checks++; if (a_txd !== 1'b0) $display("FAIL lb_start_seen: got %b, required 0", a_txd); else n_pass++;
      for (int s = 0; s < 10; s++) begin
         bad = 1'b0; seen = fr[s];
         for (int c = 0; c < 10; c++) begin
            if (a_txd !== fr[s]) begin bad = 1'b1; seen = a_txd; end
            step(1);
         end
         n_checks++;
         if (bad) $display("FAIL lb_tx_slot%0d: got %b, required %b", s, seen, fr[s]); else n_pass++;
      end
      k = 0;
      while (!a_rx_valid && k < 50) begin step(1); k++; end
      n_checks++; if (a_rx_valid !== 1'b1) $display("FAIL lb_rx_valid: got %b, required 1", a_rx_valid); else n_pass++;
      n_checks++; if (a_rx_data !== 8'hA5) $display("FAIL lb_rx_data: got %h, required a5", a_rx_data); else n_pass++;
      n_checks++; if (a_rx_level !== 5'd1) $display("FAIL lb_rx_level: got %0d, required 1", a_rx_level); else n_pass++;
      n_checks++; if ({a_err_par, a_err_frm, a_err_ovr} !== 3'b000) $display("FAIL lb_err: got %b, required 000", {a_err_par, a_err_frm, a_err_ovr}); else n_pass++;
      a_rx_ready = 1'b1; step(1); a_rx_ready = 1'b0;
      n_checks++; if (a_rx_valid !== 1'b0) $display("FAIL lb_pop_empty: got %b, required 0", a_rx_valid); else n_pass++;
      a_lb = 1'b0;
   endtask

   task automatic test_parity;
      logic [11:0] fr;
      logic bad, seen;
      int k;
      fr = {2'b11, 1'b1, 8'h07, 1'b0};
      b_lb = 1'b1;
      b_tx_data = 8'h07; b_tx_valid = 1'b1; step(1); b_tx_valid = 1'b0;
      k = 0;
      while (b_txd !== 1'b0 && k < 20) begin step(1); k++; end
      for (int s = 0; s < 12; s++) begin
         bad = 1'b0; seen = fr[s];
         for (int c = 0; c < 10; c++) begin
            if (b_txd !== fr[s]) begin bad = 1'b1; seen = b_txd; end
            step(1);
         end
         n_checks++;
         if (bad) $display("FAIL par_tx_slot%0d: got %b, required %b", s, seen, fr[s]); else n_pass++;
      end
      k = 0;
      while (!b_rx_valid && k < 50) begin step(1); k++; end
      n_checks++; if (b_rx_data !== 8'h07) $display("FAIL par_rx_data: got %h, required 07", b_rx_data); else n_pass++;
      n_checks++; if (b_err_par !== 1'b0) $display("FAIL par_clean_err: got %b, required 0", b_err_par); else n_pass++;
      b_rx_ready = 1'b1; step(1); b_rx_ready = 1'b0;
      b_lb = 1'b0;
      drive_line(1'b1, 16'({2'b11, 1'b0, 8'h07, 1'b0}), 12);
      step(5);
      n_checks++; if (b_err_par !== 1'b1) $display("FAIL par_bad_err: got %b, required 1", b_err_par); else n_pass++;
      n_checks++; if (b_rx_valid !== 1'b1 || b_rx_data !== 8'h07) $display("FAIL par_bad_pushed: got %b/%h, required 1/07", b_rx_valid, b_rx_data); else n_pass++;
      b_err_clear = 1'b1; step(1); b_err_clear = 1'b0;
      n_checks++; if (b_err_par !== 1'b0) $display("FAIL par_clear: got %b, required 0", b_err_par); else n_pass++;
      b_rx_ready = 1'b1; step(1); b_rx_ready = 1'b0;
      n_checks++; if (b_rx_level !== 3'd0) $display("FAIL par_pop_level: got %0d, required 0", b_rx_level); else n_pass++;
   endtask

   task automatic test_framing;
      drive_line(1'b0, 16'({1'b0, 8'h3C, 1'b0}), 10);
      step(5);
      n_checks++; if (a_err_frm !== 1'b1) $display("FAIL frm_err: got %b, required 1", a_err_frm); else n_pass++;
      n_checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== 8'h3C) $display("FAIL frm_pushed: got %b/%h, required 1/3c", a_rx_valid, a_rx_data); else n_pass++;
      n_checks++; if (a_err_par !== 1'b0) $display("FAIL frm_no_par: got %b, required 0", a_err_par); else n_pass++;
      a_err_clear = 1'b1; a_rx_ready = 1'b1; step(1); a_err_clear = 1'b0; a_rx_ready = 1'b0;
      n_checks++; if (a_err_frm !== 1'b0) $display("FAIL frm_clear: got %b, required 0", a_err_frm); else n_pass++;
      a_drv = 1'b0; step(3); a_drv = 1'b1;
      step(30);
      n_checks++; if (a_rx_level !== 5'd0) $display("FAIL glitch_level: got %0d, required 0", a_rx_level); else n_pass++;
      n_checks++; if (a_err_frm !== 1'b0) $display("FAIL glitch_err: got %b, required 0", a_err_frm); else n_pass++;
   endtask

   task automatic test_overrun;
      logic [7:0] d;
      b_rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = 8'h10 + 8'(i);
         drive_line(1'b1, 16'({2'b11, ^d, d, 1'b0}), 12);
      end
      step(5);
      n_checks++; if (b_rx_level !== 3'd4) $display("FAIL ovr_level: got %0d, required 4", b_rx_level); else n_pass++;
      n_checks++; if (b_err_ovr !== 1'b1) $display("FAIL ovr_flag: got %b, required 1", b_err_ovr); else n_pass++;
      n_checks++; if ({b_err_par, b_err_frm} !== 2'b00) $display("FAIL ovr_other_err: got %b, required 00", {b_err_par, b_err_frm}); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         d = 8'h10 + 8'(i);
         n_checks++;
         if (b_rx_valid !== 1'b1 || b_rx_data !== d) $display("FAIL ovr_pop%0d: got %b/%h, required 1/%h", i, b_rx_valid, b_rx_data, d); else n_pass++;
         b_rx_ready = 1'b1; step(1); b_rx_ready = 1'b0;
      end
      n_checks++; if (b_rx_valid !== 1'b0) $display("FAIL ovr_empty: got %b, required 0", b_rx_valid); else n_pass++;
   endtask

   task automatic test_backpressure;
      logic [7:0] e;
      int k;
      a_lb = 1'b1; a_rx_ready = 1'b1; a_collect = 1'b1;
      got_q.delete();
      for (int i = 0; i < 17; i++) begin
         k = 0;
         while (!a_tx_ready && k < 300) begin step(1); k++; end
         a_tx_data = 8'h40 + 8'(i); a_tx_valid = 1'b1; step(1);
      end
      a_tx_valid = 1'b0;
      n_checks++; if (a_tx_level !== 5'd16) $display("FAIL bp_full_level: got %0d, required 16", a_tx_level); else n_pass++;
      n_checks++; if (a_tx_ready !== 1'b0) $display("FAIL bp_full_ready: got %b, required 0", a_tx_ready); else n_pass++;
      a_tx_data = 8'hEE; a_tx_valid = 1'b1; step(1); a_tx_valid = 1'b0;
      n_checks++; if (a_tx_level !== 5'd16) $display("FAIL bp_ignored_push: got %0d, required 16", a_tx_level); else n_pass++;
      k = 0;
      while (!a_tx_ready && k < 200) begin step(1); k++; end
      n_checks++; if (a_tx_ready !== 1'b1 || a_tx_level !== 5'd15) $display("FAIL bp_restore: got %b/%0d, required 1/15", a_tx_ready, a_tx_level); else n_pass++;
      k = 0;
      while (got_q.size() < 17 && k < 2500) begin step(1); k++; end
      step(150);
      n_checks++; if (got_q.size() != 17) $display("FAIL bp_count: got %0d, required 17", got_q.size()); else n_pass++;
      for (int i = 0; i < 17 && i < got_q.size(); i++) begin
         e = 8'h40 + 8'(i);
         n_checks++;
         if (got_q[i] !== e) $display("FAIL bp_byte%0d: got %h, required %h", i, got_q[i], e); else n_pass++;
      end
      a_collect = 1'b0; a_rx_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      int k;
      a_lb = 1'b1;
      a_tx_data = 8'h5A; a_tx_valid = 1'b1; step(1);
      a_tx_data = 8'h77; step(1); a_tx_valid = 1'b0;
      step(34);
      n_checks++; if (a_txd !== 1'b0 || a_tx_level !== 5'd1) $display("FAIL rm_pre: got %b/%0d, required 0/1", a_txd, a_tx_level); else n_pass++;
      rst = 1'b1; step(1);
      n_checks++; if (a_txd !== 1'b1) $display("FAIL rm_txd: got %b, required 1", a_txd); else n_pass++;
      n_checks++; if ({a_tx_level, a_rx_level} !== 10'd0 || a_tx_ready !== 1'b1) $display("FAIL rm_a_levels: got %h/%b, required 0/1", {a_tx_level, a_rx_level}, a_tx_ready); else n_pass++;
      n_checks++; if (b_err_ovr !== 1'b0) $display("FAIL rm_err_clr: got %b, required 0", b_err_ovr); else n_pass++;
      rst = 1'b0; step(20);
      n_checks++; if (a_txd !== 1'b1 || a_rx_level !== 5'd0) $display("FAIL rm_quiet: got %b/%0d, required 1/0", a_txd, a_rx_level); else n_pass++;
      a_tx_data = 8'hC3; a_tx_valid = 1'b1; step(1); a_tx_valid = 1'b0;
      k = 0;
      while (!a_rx_valid && k < 200) begin step(1); k++; end
      n_checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== 8'hC3) $display("FAIL rm_clean_frame: got %b/%h, required 1/c3", a_rx_valid, a_rx_data); else n_pass++;
      n_checks++; if ({a_err_par, a_err_frm, a_err_ovr} !== 3'b000) $display("FAIL rm_clean_err: got %b, required 000", {a_err_par, a_err_frm, a_err_ovr}); else n_pass++;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      rst = 1'b1;
      a_lb = 1'b0; a_drv = 1'b1; a_tx_data = 8'h00; a_tx_valid = 1'b0; a_rx_ready = 1'b0; a_err_clear = 1'b0;
      b_lb = 1'b0; b_drv = 1'b1; b_tx_data = 8'h00; b_tx_valid = 1'b0; b_rx_ready = 1'b0; b_err_clear = 1'b0;
      a_collect = 1'b0;
      test_reset;
      test_loopback;
      test_parity;
      test_framing;
      test_overrun;
      test_backpressure;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
